// File: rtl/sd_frame_capture_pkg.sv
// Shared definitions for the sync-detector / frame-capture pair:
// FSM state encodings and default widths.
package sd_frame_capture_pkg;

    typedef enum logic [1:0] {
        SD_HUNT    = 2'd0,
        SD_CAPTURE = 2'd1,
        SD_PARITY  = 2'd2
    } sd_state_t;

    localparam int SD_PAYLOAD_W_DEF = 8;
    localparam int SD_PARITY_EN_DEF = 1;
    localparam int SD_CNT_W_DEF     = 8;

endpackage

// File: rtl/sd_sat_counter.sv
// Saturating up-counter with synchronous clear; clear beats increment.
// Single-cycle update, no backpressure.
module sd_sat_counter #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] cnt
);

    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc && (cnt != {CNT_W{1'b1}})) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/sd_frame_capture.sv
// Captures PAYLOAD_W bits (plus optional even parity) after each sync match;
// valid/perr pulse the cycle after the finish edge, no backpressure.
module sd_frame_capture
    import sd_frame_capture_pkg::*;
#(
    parameter int PAYLOAD_W = SD_PAYLOAD_W_DEF,
    parameter int PARITY_EN = SD_PARITY_EN_DEF,
    parameter int CNT_W     = SD_CNT_W_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 x,
    input  logic                 det,
    input  logic                 clr_cnt,
    output logic [PAYLOAD_W-1:0] data,
    output logic                 valid,
    output logic                 perr,
    output logic                 busy,
    output logic [CNT_W-1:0]     frame_cnt
);

    localparam int IDX_W = (PAYLOAD_W > 1) ? $clog2(PAYLOAD_W) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(PAYLOAD_W - 1);

    sd_state_t state, state_nxt;

    logic [IDX_W-1:0]     idx;
    logic [PAYLOAD_W-1:0] shreg;
    logic [PAYLOAD_W-1:0] shreg_nxt;
    logic [PAYLOAD_W-1:0] word;
    logic                 par_acc;
    logic                 start;
    logic                 shift;
    logic                 fin_good;
    logic                 fin_bad;

    assign shreg_nxt = {shreg[PAYLOAD_W-2:0], x};
    assign busy      = (state != SD_HUNT);

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= SD_HUNT;
        end else begin
            state <= state_nxt;
        end
    end

    // det is only looked at in HUNT, so a "0001" inside the payload cannot resync.
    always_comb begin
        state_nxt = state;
        start     = 1'b0;
        shift     = 1'b0;
        fin_good  = 1'b0;
        fin_bad   = 1'b0;
        word      = shreg_nxt;
        case (state)
            SD_HUNT: begin
                if (det) begin
                    state_nxt = SD_CAPTURE;
                    start     = 1'b1;
                end
            end
            SD_CAPTURE: begin
                shift = 1'b1;
                if (idx == LAST_IDX) begin
                    if (PARITY_EN != 0) begin
                        state_nxt = SD_PARITY;
                    end else begin
                        state_nxt = SD_HUNT;
                        fin_good  = 1'b1;
                    end
                end
            end
            SD_PARITY: begin
                state_nxt = SD_HUNT;
                word      = shreg;
                if (par_acc ^ x) begin
                    fin_bad = 1'b1;
                end else begin
                    fin_good = 1'b1;
                end
            end
            default: begin
                state_nxt = SD_HUNT;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            idx     <= '0;
            shreg   <= '0;
            par_acc <= 1'b0;
            data    <= '0;
            valid   <= 1'b0;
            perr    <= 1'b0;
        end else begin
            valid <= fin_good;
            perr  <= fin_bad;
            if (start) begin
                idx     <= '0;
                par_acc <= 1'b0;
            end
            if (shift) begin
                shreg   <= shreg_nxt;
                par_acc <= par_acc ^ x;
                idx     <= idx + IDX_W'(1);
            end
            // Whole-word load only on a good finish; data never shows a partial frame.
            if (fin_good) begin
                data <= word;
            end
        end
    end

    sd_sat_counter #(
        .CNT_W(CNT_W)
    ) u_frame_cnt (
        .clk(clk),
        .rst(rst),
        .inc(fin_good),
        .clr(clr_cnt),
        .cnt(frame_cnt)
    );

endmodule

// File: tb/tb_sd_frame_capture.sv
// Scoreboard bench: frame-level reference model pushes expected pulses, monitors pop and compare.
module tb_sd_frame_capture;

    logic clk = 1'b0;
    always #25 clk = ~clk;

    logic rst, x, det, clr0, clr1, x2, det2, clr2;
    logic [7:0] d0, d1;
    logic [3:0] d2;
    logic v0, v1, v2, p0, p1, p2, b0, b1, b2;
    logic [7:0] c0, c2;
    logic [1:0] c1;

    sd_frame_capture u0 (
        .clk(clk), .rst(rst), .x(x), .det(det), .clr_cnt(clr0),
        .data(d0), .valid(v0), .perr(p0), .busy(b0), .frame_cnt(c0)
    );

    sd_frame_capture #(.CNT_W(2)) u1 (
        .clk(clk), .rst(rst), .x(x), .det(det), .clr_cnt(clr1),
        .data(d1), .valid(v1), .perr(p1), .busy(b1), .frame_cnt(c1)
    );

    sd_frame_capture #(.PAYLOAD_W(4), .PARITY_EN(0)) u2 (
        .clk(clk), .rst(rst), .x(x2), .det(det2), .clr_cnt(clr2),
        .data(d2), .valid(v2), .perr(p2), .busy(b2), .frame_cnt(c2)
    );

    typedef struct {
        bit         bad;
        logic [7:0] d;
        int         cnt;
    } exp_t;

    exp_t q0[$], q1[$], q2[$];
    exp_t e0, e1, e2;
    bit   h0, h1, h2;

    int n_chk = 0;
    int n_fail = 0;

    logic [7:0] m_data = 8'h00;
    logic [3:0] m_data2 = 4'h0;
    int m_cnt0 = 0, m_cnt1 = 0, m_cnt2 = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic chk_pulse(input string nm, input bit have, input exp_t e,
                             input logic v, input logic p, input logic [7:0] d, input int cnt);
        if (!have) begin
            n_chk++;
            n_fail++;
            $display("FAIL %s_unexpected: got valid=%0b perr=%0b expected no pulse", nm, v, p);
        end else begin
            chk({nm, "_valid"}, 32'(v), 32'(!e.bad));
            chk({nm, "_perr"}, 32'(p), 32'(e.bad));
            chk({nm, "_data"}, 32'(d), 32'(e.d));
            chk({nm, "_cnt"}, 32'(cnt), 32'(e.cnt));
        end
    endtask

    always @(negedge clk) begin
        if (v0 || p0) begin
            h0 = (q0.size() > 0);
            if (h0) e0 = q0.pop_front();
            chk_pulse("u0", h0, e0, v0, p0, d0, int'(c0));
        end
    end

    always @(negedge clk) begin
        if (v1 || p1) begin
            h1 = (q1.size() > 0);
            if (h1) e1 = q1.pop_front();
            chk_pulse("u1", h1, e1, v1, p1, d1, int'(c1));
        end
    end

    always @(negedge clk) begin
        if (v2 || p2) begin
            h2 = (q2.size() > 0);
            if (h2) e2 = q2.pop_front();
            chk_pulse("u2", h2, e2, v2, p2, {4'h0, d2}, int'(c2));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int sat_inc(input int c, input int maxv);
        return (c < maxv) ? c + 1 : maxv;
    endfunction

    // One 8-bit frame on the shared stream; dmask marks payload bits where det is raised.
    task automatic frame8(input logic [7:0] pay, input logic par, input logic [7:0] dmask,
                          input bit cl0, input bit cl1);
        bit bad;
        det = 1'b1;
        x = 1'($urandom);
        tick();
        chk("busy_start", 32'(b0), 32'd1);
        for (int i = 0; i < 8; i++) begin
            det = dmask[7-i];
            x = pay[7-i];
            tick();
        end
        det = 1'b0;
        x = par;
        clr0 = cl0;
        clr1 = cl1;
        bad = ((^pay) ^ par) != 1'b0;
        if (!bad) begin
            m_data = pay;
            m_cnt0 = sat_inc(m_cnt0, 255);
            m_cnt1 = sat_inc(m_cnt1, 3);
        end
        if (cl0) m_cnt0 = 0;
        if (cl1) m_cnt1 = 0;
        q0.push_back('{bad, m_data, m_cnt0});
        q1.push_back('{bad, m_data, m_cnt1});
        tick();
        clr0 = 1'b0;
        clr1 = 1'b0;
        chk("valid_after_F", 32'(v0), 32'(!bad));
        chk("perr_after_F", 32'(p0), 32'(bad));
        chk("busy_after_F", 32'(b0), 32'd0);
    endtask

    task automatic frame4(input logic [3:0] pay);
        det2 = 1'b1;
        x2 = 1'($urandom);
        tick();
        chk("u2_busy_start", 32'(b2), 32'd1);
        for (int i = 0; i < 4; i++) begin
            det2 = 1'($urandom);
            x2 = pay[3-i];
            if (i == 3) begin
                m_data2 = pay;
                m_cnt2 = sat_inc(m_cnt2, 255);
                q2.push_back('{1'b0, {4'h0, m_data2}, m_cnt2});
            end
            tick();
        end
        det2 = 1'b0;
        chk("u2_valid_after_k4", 32'(v2), 32'd1);
        chk("u2_busy_after_F", 32'(b2), 32'd0);
    endtask

    task automatic idle(input int n, input bit cl0, input bit cl1);
        for (int i = 0; i < n; i++) begin
            det = 1'b0;
            x = 1'($urandom);
            clr0 = cl0;
            clr1 = cl1;
            tick();
        end
        clr0 = 1'b0;
        clr1 = 1'b0;
        if (n > 0 && cl0) m_cnt0 = 0;
        if (n > 0 && cl1) m_cnt1 = 0;
    endtask

    initial begin
        logic [7:0] pay;
        logic [3:0] pay4;
        bit bad;
        rst = 1'b0; x = 1'b0; det = 1'b0; clr0 = 1'b0; clr1 = 1'b0;
        x2 = 1'b0; det2 = 1'b0; clr2 = 1'b0;
        tick();
        tick();
        chk("rst_busy", 32'(b0), 32'd0);
        chk("rst_valid", 32'(v0), 32'd0);
        chk("rst_perr", 32'(p0), 32'd0);
        chk("rst_data", 32'(d0), 32'd0);
        chk("rst_cnt", 32'(c0), 32'd0);
        rst = 1'b1;
        idle(2, 1'b0, 1'b0);

        // Good frame, then bad parity keeps data/count.
        frame8(8'hA5, 1'b0, 8'h00, 1'b0, 1'b0);
        chk("t1_cnt", 32'(c0), 32'd1);
        chk("t1_valid_one_cycle", 32'(v0), 32'd1);
        tick();
        chk("t1_valid_dropped", 32'(v0), 32'd0);
        frame8(8'hA5, 1'b1, 8'h00, 1'b0, 1'b0);
        chk("t2_data_hold", 32'(d0), 32'hA5);
        chk("t2_cnt_hold", 32'(c0), 32'd1);
        idle(1, 1'b0, 1'b0);

        // Embedded 0001 with det pulses mid-payload, then back-to-back frame.
        frame8(8'h11, 1'b0, 8'b0001_0001, 1'b0, 1'b0);
        frame8(8'hFF, 1'b0, 8'h00, 1'b0, 1'b0);
        chk("t3_data", 32'(d0), 32'hFF);
        idle(2, 1'b0, 1'b0);

        // Reset after four payload bits.
        det = 1'b1;
        tick();
        det = 1'b0;
        for (int i = 0; i < 4; i++) begin
            x = 1'($urandom);
            tick();
        end
        rst = 1'b0;
        tick();
        chk("t4_busy", 32'(b0), 32'd0);
        chk("t4_valid", 32'(v0), 32'd0);
        chk("t4_perr", 32'(p0), 32'd0);
        chk("t4_cnt", 32'(c0), 32'd0);
        chk("t4_data", 32'(d0), 32'd0);
        rst = 1'b1;
        m_data = 8'h00; m_cnt0 = 0; m_cnt1 = 0; m_data2 = 4'h0; m_cnt2 = 0;
        idle(3, 1'b0, 1'b0);
        frame8(8'h3C, 1'b0, 8'h00, 1'b0, 1'b0);
        chk("t4_recover_data", 32'(d0), 32'h3C);

        // Saturation of the 2-bit counter, then clear on a finish edge.
        idle(1, 1'b0, 1'b1);
        for (int n = 0; n < 5; n++) begin
            pay = 8'($urandom);
            frame8(pay, ^pay, 8'h00, 1'b0, 1'b0);
        end
        chk("t5_sat", 32'(c1), 32'd3);
        pay = 8'($urandom);
        frame8(pay, ^pay, 8'h00, 1'b0, 1'b1);
        chk("t5_clr_cnt", 32'(c1), 32'd0);
        chk("t5_clr_valid", 32'(v1), 32'd1);

        // Randomized frames, corruption, gaps and clears.
        for (int n = 0; n < 40; n++) begin
            pay = 8'($urandom);
            bad = ($urandom_range(0, 3) == 0);
            frame8(pay, (^pay) ^ bad, 8'($urandom),
                   ($urandom_range(0, 5) == 0), ($urandom_range(0, 5) == 0));
            idle($urandom_range(0, 2), ($urandom_range(0, 7) == 0), ($urandom_range(0, 7) == 0));
        end

        // No-parity 4-bit instance.
        frame4(4'b1001);
        chk("t6_data", 32'(d2), 32'h9);
        for (int n = 0; n < 10; n++) begin
            pay4 = 4'($urandom);
            frame4(pay4);
            for (int g = 0; g < int'($urandom_range(0, 2)); g++) begin
                det2 = 1'b0;
                x2 = 1'($urandom);
                tick();
            end
        end

        repeat (4) tick();
        chk("q0_drained", 32'(q0.size()), 32'd0);
        chk("q1_drained", 32'(q1.size()), 32'd0);
        chk("q2_drained", 32'(q2.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
